// File: rtl/cgra_obi_mem_responder.sv
// OBI memory responder: word-addressed reads and byte-enabled writes served from
// an internal array, with fixed response latency and bounded outstanding count.
package cgra_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cgra_obi_mem_responder
  import cgra_obi_pkg::*;
#(
  parameter int          NUM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          WAIT_CYCLES     = 0,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  input  logic        set_retentive_i,
  output logic        idle_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  localparam int          AW       = $clog2(NUM_WORDS);
  localparam int          DEPTH    = 1 + WAIT_CYCLES;
  localparam int          OW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [31:0] OOR_DATA = 32'hBADCAB1E;

  // Handshake: a request transfers in any cycle where req and gnt are both high;
  // rvalid is a single-cycle pulse with no ready, so responses are never stalled.

  logic [31:0]   mem_q [NUM_WORDS];
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          gnt;
  logic          accept;
  logic          rd_accept;
  logic          wr_accept;
  logic [31:0]   resp_data;

  logic [DEPTH-1:0] pipe_vld_q;
  logic [31:0]      pipe_data_q [DEPTH];
  logic             rvalid;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic [15:0]   wr_count_q, wr_count_d;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign offset   = slave_req_i.addr - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign word_idx = offset[AW+1:2];

  assign gnt       = slave_req_i.req & ~rst_i & ~set_retentive_i & (outstanding_q < MAX_OUT);
  assign accept    = slave_req_i.req & gnt;
  assign rd_accept = accept & ~slave_req_i.we;
  assign wr_accept = accept &  slave_req_i.we;

  always_comb begin
    resp_data = 32'h0;
    if (!slave_req_i.we) begin
      resp_data = in_range ? mem_q[word_idx] : OOR_DATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (slave_req_i.be[k]) begin
          mem_q[word_idx][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        pipe_data_q[s] <= 32'h0;
      end
    end else begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        pipe_vld_q[s]  <= pipe_vld_q[s-1];
        pipe_data_q[s] <= pipe_data_q[s-1];
      end
      pipe_vld_q[0]  <= accept;
      pipe_data_q[0] <= accept ? resp_data : 32'h0;
    end
  end

  assign rvalid = pipe_vld_q[DEPTH-1];

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rvalid) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!accept && rvalid) begin
      outstanding_d = outstanding_q - OW'(1);
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_accept && rd_count_q != 16'hFFFF) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_accept && wr_count_q != 16'hFFFF) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      rd_count_q    <= 16'h0;
      wr_count_q    <= 16'h0;
    end else begin
      outstanding_q <= outstanding_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = rvalid;
  assign slave_resp_o.rdata  = rvalid ? pipe_data_q[DEPTH-1] : 32'h0;
  assign idle_o              = (outstanding_q == '0);
  assign rd_count_o          = rd_count_q;
  assign wr_count_o          = wr_count_q;

endmodule

// File: tb/tb_cgra_obi_mem_responder.sv
// Bench for cgra_obi_mem_responder: three instances (full-rate and latency-limited)
// checked every cycle against a latency-schedule model of the responder.
module tb_cgra_obi_mem_responder;
  import cgra_obi_pkg::*;

  localparam int          NI   = 3;
  localparam int          NW   = 1024;
  localparam logic [31:0] BASE = 32'h4000_0000;

  int wait_m [NI] = '{0, 3, 0};
  int max_m  [NI] = '{2, 2, 2};

  logic        clk = 1'b0;
  logic        rst;
  obi_req_t    req_v  [NI];
  obi_resp_t   resp_v [NI];
  logic        ret_v  [NI];
  logic        idle_v [NI];
  logic [15:0] rdc_v  [NI];
  logic [15:0] wrc_v  [NI];

  always #5 clk = ~clk;

  cgra_obi_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .MAX_OUTSTANDING(2)) u_fast (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req_v[0]), .slave_resp_o(resp_v[0]),
    .set_retentive_i(ret_v[0]), .idle_o(idle_v[0]), .rd_count_o(rdc_v[0]), .wr_count_o(wrc_v[0]));
  cgra_obi_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .MAX_OUTSTANDING(2)) u_slow (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req_v[1]), .slave_resp_o(resp_v[1]),
    .set_retentive_i(ret_v[1]), .idle_o(idle_v[1]), .rd_count_o(rdc_v[1]), .wr_count_o(wrc_v[1]));
  cgra_obi_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .MAX_OUTSTANDING(2)) u_wr (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req_v[2]), .slave_resp_o(resp_v[2]),
    .set_retentive_i(ret_v[2]), .idle_o(idle_v[2]), .rd_count_o(rdc_v[2]), .wr_count_o(wrc_v[2]));

  // Reference model: memory image, responses scheduled by due cycle, counts.
  logic [31:0] mem_m  [NI][NW];
  bit          memk_m [NI][NW];
  bit          sv_m   [NI][16];
  logic [31:0] sd_m   [NI][16];
  bit          sc_m   [NI][16];
  int          out_m  [NI];
  int          rdc_m  [NI];
  int          wrc_m  [NI];
  int          cyc;

  bit          egnt  [NI];
  logic [66:0] exp_v [NI];
  logic [66:0] msk_v [NI];
  int          vectors;
  int          miscompares;

  function automatic logic [66:0] obs(input int i);
    return {resp_v[i].gnt, resp_v[i].rvalid, resp_v[i].rdata, idle_v[i], rdc_v[i], wrc_v[i]};
  endfunction

  task automatic eval();
    int s;
    logic [31:0] erd;
    bit rchk;
    #1;
    s = cyc % 16;
    for (int i = 0; i < NI; i++) begin
      egnt[i]  = req_v[i].req && !rst && !ret_v[i] && (out_m[i] < max_m[i]);
      erd      = sv_m[i][s] ? sd_m[i][s] : 32'h0;
      rchk     = !sv_m[i][s] || sc_m[i][s];
      exp_v[i] = {egnt[i], sv_m[i][s], erd, out_m[i] == 0, 16'(rdc_m[i]), 16'(wrc_m[i])};
      msk_v[i] = {2'b11, rchk ? 32'hFFFF_FFFF : 32'h0, 33'h1_FFFF_FFFF};
    end
  endtask

  task automatic advance();
    int s, d, idx;
    logic [31:0] off;
    bit inr;
    @(posedge clk);
    s = cyc % 16;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) sv_m[i][k] = 1'b0;
        out_m[i] = 0; rdc_m[i] = 0; wrc_m[i] = 0;
      end else begin
        if (sv_m[i][s]) begin
          sv_m[i][s] = 1'b0;
          out_m[i]--;
        end
        if (egnt[i]) begin
          off = req_v[i].addr - BASE;
          inr = off < NW * 4;
          idx = inr ? int'(off >> 2) : 0;
          d   = (cyc + 1 + wait_m[i]) % 16;
          if (req_v[i].we) begin
            if (inr) begin
              for (int b = 0; b < 4; b++)
                if (req_v[i].be[b]) mem_m[i][idx][8*b +: 8] = req_v[i].wdata[8*b +: 8];
              memk_m[i][idx] = memk_m[i][idx] || (req_v[i].be == 4'hF);
            end
            sd_m[i][d] = 32'h0;
            sc_m[i][d] = 1'b1;
            if (wrc_m[i] < 65535) wrc_m[i]++;
          end else begin
            sd_m[i][d] = inr ? mem_m[i][idx] : 32'hBADCAB1E;
            sc_m[i][d] = inr ? memk_m[i][idx] : 1'b1;
            if (rdc_m[i] < 65535) rdc_m[i]++;
          end
          sv_m[i][d] = 1'b1;
          out_m[i]++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      req_v[i] = '0;
      ret_v[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    eval(); advance();
    eval();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
        miscompares++;
        $display("FAIL reset_model inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
      end
    end
    advance();
    rst = 1'b0;
    eval();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ({resp_v[i].rvalid, resp_v[i].rdata, idle_v[i], rdc_v[i], wrc_v[i]} !== {1'b0, 32'h0, 1'b1, 16'h0, 16'h0}) begin
        miscompares++;
        $display("FAIL reset_state inst%0d got rv=%b rd=%h idle=%b rdc=%h wrc=%h want 0/0/1/0/0",
                 i, resp_v[i].rvalid, resp_v[i].rdata, idle_v[i], rdc_v[i], wrc_v[i]);
      end
    end
    advance();
  endtask

  task automatic test_raw();
    obi_req_t seq [4];
    seq[0] = '{1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF};
    seq[1] = '{1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0};
    seq[2] = '0;
    seq[3] = '0;
    for (int t = 0; t < 4; t++) begin
      req_v[0] = seq[t];
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL raw inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (t < 2) begin
        vectors++;
        if (resp_v[0].gnt !== 1'b1) begin
          miscompares++;
          $display("FAIL raw_gnt t%0d got %b want 1", t, resp_v[0].gnt);
        end
      end
      if (t == 2) begin
        vectors++;
        if ({resp_v[0].rvalid, resp_v[0].rdata, rdc_v[0], wrc_v[0]} !== {1'b1, 32'hDEADBEEF, 16'd1, 16'd1}) begin
          miscompares++;
          $display("FAIL raw_read got rv=%b rd=%h rdc=%0d wrc=%0d want 1/deadbeef/1/1",
                   resp_v[0].rvalid, resp_v[0].rdata, rdc_v[0], wrc_v[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_byte_en();
    obi_req_t seq [4];
    seq[0] = '{1'b1, 1'b1, 4'hF,    BASE + 32'h20, 32'h11223344};
    seq[1] = '{1'b1, 1'b1, 4'b0101, BASE + 32'h20, 32'hAABBCCDD};
    seq[2] = '{1'b1, 1'b0, 4'hF,    BASE + 32'h20, 32'h0};
    seq[3] = '0;
    for (int t = 0; t < 4; t++) begin
      req_v[0] = seq[t];
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL byte_en inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (t == 3) begin
        vectors++;
        if (resp_v[0].rdata !== 32'h11BB33DD) begin
          miscompares++;
          $display("FAIL byte_en_read got %h want 11bb33dd", resp_v[0].rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_out_of_range();
    obi_req_t    seq [8];
    logic [31:0] lit [8];
    seq[0] = '{1'b1, 1'b1, 4'hF, BASE,            32'h12345678};
    seq[1] = '{1'b1, 1'b1, 4'hF, BASE + 32'hFFC,  32'hCAFEF00D};
    seq[2] = '{1'b1, 1'b0, 4'hF, BASE + 32'h1000, 32'h0};
    seq[3] = '{1'b1, 1'b1, 4'hF, BASE + 32'h1000, 32'hFFFFFFFF};
    seq[4] = '{1'b1, 1'b0, 4'hF, BASE - 32'h4,    32'h0};
    seq[5] = '{1'b1, 1'b0, 4'hF, BASE,            32'h0};
    seq[6] = '{1'b1, 1'b0, 4'hF, BASE + 32'hFFC,  32'h0};
    seq[7] = '0;
    lit = '{32'h0, 32'h0, 32'h0, 32'hBADCAB1E, 32'h0, 32'hBADCAB1E, 32'h12345678, 32'hCAFEF00D};
    for (int t = 0; t < 8; t++) begin
      req_v[0] = seq[t];
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL oor inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (t >= 1) begin
        vectors++;
        if ({resp_v[0].rvalid, resp_v[0].rdata} !== {1'b1, lit[t]}) begin
          miscompares++;
          $display("FAIL oor_resp t%0d got rv=%b rd=%h want 1/%h", t, resp_v[0].rvalid, resp_v[0].rdata, lit[t]);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int k, t0;
    int gcyc [$];
    int rcyc [$];
    logic [31:0] exp_q [$];
    bit ok;
    k = 0;
    for (int t = 0; t < 40 && (k < 4 || !idle_v[1]); t++) begin
      req_v[1] = (k < 4) ? '{1'b1, 1'b1, 4'hF, BASE + 32'h80 + 32'(4 * k), 32'hA0000000 + 32'(k)} : '0;
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL b2b_fill inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (resp_v[1].gnt && k < 4) k++;
      advance();
    end
    k = 0;
    t0 = cyc;
    for (int t = 0; t < 40 && (k < 4 || exp_q.size() != 0); t++) begin
      req_v[1] = (k < 4) ? '{1'b1, 1'b0, 4'hF, BASE + 32'h80 + 32'(4 * k), 32'h0} : '0;
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL b2b inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (resp_v[1].rvalid) begin
        rcyc.push_back(cyc - t0);
        vectors++;
        if (exp_q.size() == 0 || resp_v[1].rdata !== exp_q[0]) begin
          miscompares++;
          $display("FAIL b2b_order got %h want %h", resp_v[1].rdata, exp_q.size() ? exp_q[0] : 32'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (resp_v[1].gnt && k < 4) begin
        gcyc.push_back(cyc - t0);
        exp_q.push_back(32'hA0000000 + 32'(k));
        k++;
      end
      advance();
    end
    ok = gcyc.size() == 4;
    if (ok) ok = gcyc[0] == 0 && gcyc[1] == 1 && gcyc[2] == 5 && gcyc[3] == 6;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_gnt_cycles got %p want 0 1 5 6", gcyc);
    end
    ok = rcyc.size() == 4;
    if (ok) ok = rcyc[0] == 4 && rcyc[1] == 5 && rcyc[2] == 9 && rcyc[3] == 10;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_rvalid_cycles got %p want 4 5 9 10", rcyc);
    end
  endtask

  task automatic test_retention();
    int nrv, k;
    bit done;
    k = 0;
    for (int t = 0; t < 20 && (k < 1 || !idle_v[1]); t++) begin
      req_v[1] = (k < 1) ? '{1'b1, 1'b1, 4'hF, BASE + 32'h40, 32'h5A5AA5A5} : '0;
      eval();
      if (resp_v[1].gnt) k++;
      advance();
    end
    nrv = 0;
    for (int t = 0; t < 14; t++) begin
      req_v[1] = '{1'b1, 1'b0, 4'hF, BASE + 32'h40, 32'h0};
      ret_v[1] = (t >= 2);
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL retention inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      if (resp_v[1].rvalid) begin
        nrv++;
        vectors++;
        if (resp_v[1].rdata !== 32'h5A5AA5A5) begin
          miscompares++;
          $display("FAIL retention_data got %h want 5a5aa5a5", resp_v[1].rdata);
        end
      end
      if (t >= 2) begin
        vectors++;
        if (resp_v[1].gnt !== 1'b0) begin
          miscompares++;
          $display("FAIL retention_gnt t%0d got %b want 0", t, resp_v[1].gnt);
        end
      end
      advance();
    end
    vectors++;
    if (nrv != 2 || idle_v[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL retention_drain got rvalids=%0d idle=%b want 2/1", nrv, idle_v[1]);
    end
    ret_v[1] = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 8 && !done; t++) begin
      req_v[1] = (t == 0) ? '{1'b1, 1'b0, 4'hF, BASE + 32'h40, 32'h0} : '0;
      eval();
      if (resp_v[1].rvalid) begin
        done = 1'b1;
        vectors++;
        if (resp_v[1].rdata !== 32'h5A5AA5A5) begin
          miscompares++;
          $display("FAIL retention_keep got %h want 5a5aa5a5", resp_v[1].rdata);
        end
      end
      advance();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL retention_keep_timeout got no rvalid want rvalid");
    end
  endtask

  task automatic test_reset_inflight();
    req_v[1] = '{1'b1, 1'b0, 4'hF, BASE + 32'h40, 32'h0};
    eval(); advance();
    req_v[1] = '0;
    rst = 1'b1;
    eval(); advance();
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL rst_inflight inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      vectors++;
      if ({resp_v[1].rvalid, idle_v[1], rdc_v[1], wrc_v[1]} !== {1'b0, 1'b1, 16'h0, 16'h0}) begin
        miscompares++;
        $display("FAIL rst_inflight_state t%0d got rv=%b idle=%b rdc=%h wrc=%h want 0/1/0/0",
                 t, resp_v[1].rvalid, idle_v[1], rdc_v[1], wrc_v[1]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 9))
          0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 255) * 4);
          1:       a = BASE - 32'($urandom_range(1, 64) * 4);
          2:       a = BASE + 32'hFFC;
          default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        endcase
        req_v[i] = '{($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom};
        ret_v[i] = ($urandom_range(0, 9) == 0);
      end
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      advance();
    end
    idle_all();
    for (int t = 0; t < 10; t++) begin
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL random_drain inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 65540; t++) begin
      req_v[0] = '{1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0};
      req_v[2] = '{1'b1, 1'b1, 4'($urandom_range(0, 15)), BASE + 32'h4, $urandom};
      eval();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((obs(i) & msk_v[i]) !== (exp_v[i] & msk_v[i])) begin
          miscompares++;
          $display("FAIL saturation inst%0d cyc%0d got %h want %h", i, cyc, obs(i) & msk_v[i], exp_v[i] & msk_v[i]);
        end
      end
      advance();
    end
    idle_all();
    eval();
    vectors++;
    if (rdc_v[0] !== 16'hFFFF || wrc_v[2] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL saturation_hold got rdc=%h wrc=%h want ffff/ffff", rdc_v[0], wrc_v[2]);
    end
    advance();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    idle_all();
    @(negedge clk);
    test_reset();
    test_raw();
    test_byte_en();
    test_out_of_range();
    test_back_to_back();
    test_retention();
    test_reset_inflight();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
